// File: rtl/opc7_bus_arbiter.sv
// Shares one memory/IO port between the opc7 CPU and a single DMA requester,
// stalling the CPU via cpu_clken. Define ARB_DMA_FAIR_EN for DMA-favoured ties with a burst cap.
module opc7_bus_arbiter #(
    parameter int WAIT_STATES   = 1,
    parameter int MAX_DMA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] cpu_addr,
    input  logic [31:0] cpu_dout,
    input  logic        cpu_rnw,
    input  logic        cpu_vpa,
    input  logic        cpu_vda,
    input  logic        cpu_vio,
    output logic [31:0] cpu_din,
    output logic        cpu_clken,
    input  logic        dma_req,
    input  logic [19:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_rnw,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [19:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rnw,
    output logic        mem_ce,
    output logic        io_ce,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] io_rdata
);
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $error("opc7_bus_arbiter: WAIT_STATES must be 0..15");
    end
    if (MAX_DMA_BURST < 0 || MAX_DMA_BURST > 15) begin : g_bad_burst
        $error("opc7_bus_arbiter: MAX_DMA_BURST must be 0..15");
    end

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [19:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        bus_rnw_q;
    logic        mem_ce_q;
    logic        io_ce_q;

    logic cpu_req, dma_first, grant_dma, grant_cpu, last;

    assign cpu_req = cpu_vpa | cpu_vda | cpu_vio;

`ifdef ARB_DMA_FAIR_EN
    localparam logic [3:0] MAX_B = 4'(MAX_DMA_BURST);
    logic [3:0] fair_q;
    // DMA takes ties until it has won MAX_B of them back to back against a waiting CPU
    assign dma_first = (fair_q < MAX_B);
`else
    assign dma_first = 1'b0;
`endif

    assign grant_dma = dma_req & (~cpu_req | dma_first);
    assign grant_cpu = cpu_req & ~grant_dma;
    // Reset kills the completion so an aborted access never acks or releases the CPU
    assign last      = ~reset && (state_q != IDLE) && (wcnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            bus_addr_q  <= 20'd0;
            bus_wdata_q <= 32'd0;
            bus_rnw_q   <= 1'b1;
            mem_ce_q    <= 1'b0;
            io_ce_q     <= 1'b0;
`ifdef ARB_DMA_FAIR_EN
            fair_q      <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_cpu) begin
                        state_q     <= CPU_ACC;
                        wcnt_q      <= WS;
                        bus_addr_q  <= cpu_addr;
                        bus_wdata_q <= cpu_dout;
                        bus_rnw_q   <= cpu_rnw;
                        mem_ce_q    <= (cpu_vpa | cpu_vda) & ~cpu_vio;
                        io_ce_q     <= cpu_vio;
                    end else if (grant_dma) begin
                        state_q     <= DMA_ACC;
                        wcnt_q      <= WS;
                        bus_addr_q  <= dma_addr;
                        bus_wdata_q <= dma_wdata;
                        bus_rnw_q   <= dma_rnw;
                        mem_ce_q    <= 1'b1;
                        io_ce_q     <= 1'b0;
                    end
                end
                default: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        state_q   <= IDLE;
                        bus_rnw_q <= 1'b1;
                        mem_ce_q  <= 1'b0;
                        io_ce_q   <= 1'b0;
                    end
                end
            endcase
`ifdef ARB_DMA_FAIR_EN
            if (state_q == IDLE) begin
                if (grant_cpu)
                    fair_q <= 4'd0;
                else if (grant_dma && cpu_req)
                    fair_q <= fair_q + 4'd1;
            end
`endif
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rnw   = bus_rnw_q;
    assign mem_ce    = mem_ce_q;
    assign io_ce     = io_ce_q;

    // In IDLE the CPU runs its internal cycle unless it is asking for the bus
    assign cpu_clken = reset | ((state_q == IDLE) ? ~cpu_req : (last && state_q == CPU_ACC));
    assign cpu_din   = (last && state_q == CPU_ACC) ? (io_ce_q ? io_rdata : mem_rdata) : 32'd0;
    assign dma_ack   = last && (state_q == DMA_ACC);
    assign dma_rdata = dma_ack ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_opc7_bus_arbiter.sv
// Bench for opc7_bus_arbiter: four instances (WAIT_STATES 0..3) on shared inputs,
// one lane checked at a time; completions are matched against a scoreboard queue.
module tb_opc7_bus_arbiter;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [19:0] cpu_addr = '0;
    logic [31:0] cpu_dout = '0;
    logic cpu_rnw = 1'b1, cpu_vpa = 1'b0, cpu_vda = 1'b0, cpu_vio = 1'b0;
    logic dma_req = 1'b0, dma_rnw = 1'b1;
    logic [19:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic [31:0] mem_rdata = '0, io_rdata = '0;

    logic [NL-1:0][31:0] din_w, dma_rdata_w, bus_wdata_w;
    logic [NL-1:0][19:0] bus_addr_w;
    logic [NL-1:0] clken_w, ack_w, bus_rnw_w, mem_ce_w, io_ce_w;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        opc7_bus_arbiter #(.WAIT_STATES(g), .MAX_DMA_BURST(2)) u_dut (
            .clk(clk), .reset(reset),
            .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
            .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_vio(cpu_vio),
            .cpu_din(din_w[g]), .cpu_clken(clken_w[g]),
            .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rnw(dma_rnw),
            .dma_ack(ack_w[g]), .dma_rdata(dma_rdata_w[g]),
            .bus_addr(bus_addr_w[g]), .bus_wdata(bus_wdata_w[g]), .bus_rnw(bus_rnw_w[g]),
            .mem_ce(mem_ce_w[g]), .io_ce(io_ce_w[g]),
            .mem_rdata(mem_rdata), .io_rdata(io_rdata)
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int sel = 0;

    typedef struct {
        bit          dma;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lane=%0d cyc=%0d got=%0h exp=%0h", tag, sel, cyc, got, exp);
        end
    endtask

    task automatic sb_pop(input bit is_dma, input logic [31:0] d);
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("sb_kind", is_dma, e.dma);
        chk("sb_data", d, e.data);
        chk("sb_cyc", cyc, e.cyc);
    endtask

    // Completion monitor for the lane under test
    always @(negedge clk) begin
        if (!reset) begin
            if ((cpu_vpa | cpu_vda | cpu_vio) && clken_w[sel]) sb_pop(1'b0, din_w[sel]);
            if (ack_w[sel]) sb_pop(1'b1, dma_rdata_w[sel]);
        end
    end

    task automatic idle_in();
        {cpu_vpa, cpu_vda, cpu_vio} = 3'b000;
        cpu_rnw = 1'b1;
        dma_req = 1'b0;
        dma_rnw = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cpu_access(input int l, input int w, input bit pa, input bit da, input bit io,
                              input bit rw, input logic [19:0] a, input logic [31:0] d,
                              input logic [31:0] rd);
        bit act;
        sel = l;
        cpu_vpa = pa; cpu_vda = da; cpu_vio = io; cpu_rnw = rw;
        cpu_addr = a; cpu_dout = d;
        sb.push_back('{1'b0, rd, cyc + 1 + w});
        for (int k = 0; k <= w + 2; k++) begin
            @(negedge clk);
            act = (k >= 1 && k <= w + 1);
            chk("cpu_ce", io ? io_ce_w[l] : mem_ce_w[l], act);
            chk("cpu_ce_other", io ? mem_ce_w[l] : io_ce_w[l], 0);
            chk("cpu_clken", clken_w[l], (k >= w + 1));
            if (act) begin
                chk("cpu_bus_addr", bus_addr_w[l], a);
                chk("cpu_bus_rnw", bus_rnw_w[l], rw);
                if (!rw) chk("cpu_bus_wdata", bus_wdata_w[l], d);
            end
            if (k <= w) chk("cpu_din_idle", din_w[l], 0);
            if (k == w + 1) begin
                @(posedge clk); #1;
                idle_in();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic dma_access(input int l, input int w, input bit rw, input logic [19:0] a,
                              input logic [31:0] d, input bit early);
        bit act;
        sel = l;
        dma_req = 1'b1; dma_rnw = rw; dma_addr = a; dma_wdata = d;
        sb.push_back('{1'b1, mem_rdata, cyc + 1 + w});
        for (int k = 0; k <= w + 2; k++) begin
            @(negedge clk);
            act = (k >= 1 && k <= w + 1);
            chk("dma_mem_ce", mem_ce_w[l], act);
            chk("dma_io_ce", io_ce_w[l], 0);
            chk("dma_clken", clken_w[l], !act);
            if (act) begin
                chk("dma_bus_addr", bus_addr_w[l], a);
                chk("dma_bus_rnw", bus_rnw_w[l], rw);
                if (!rw) chk("dma_bus_wdata", bus_wdata_w[l], d);
            end
            if (k <= w) begin
                chk("dma_ack_early", ack_w[l], 0);
                chk("dma_rdata_idle", dma_rdata_w[l], 0);
            end
            if (k == w + 1 || (early && k == 1)) begin
                @(posedge clk); #1;
                dma_req = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    // Acts as both masters: each drops its request after its n-th completion
    task automatic serve(input int l, input int ncpu, input int ndma, input int budget);
        bit drop_c, drop_d;
        for (int k = 0; k < budget && (ncpu > 0 || ndma > 0); k++) begin
            @(negedge clk);
            drop_c = 1'b0; drop_d = 1'b0;
            if (ncpu > 0 && clken_w[l]) begin ncpu--; drop_c = (ncpu == 0); end
            if (ndma > 0 && ack_w[l])   begin ndma--; drop_d = (ndma == 0); end
            @(posedge clk); #1;
            if (drop_c) {cpu_vpa, cpu_vda, cpu_vio} = 3'b000;
            if (drop_d) dma_req = 1'b0;
        end
        chk("serve_timeout", ncpu + ndma, 0);
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        idle_in();
        mem_rdata = 32'h1234ABCD;
        io_rdata  = 32'h55AA0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            sel = l;
            chk("rst_mem_ce", mem_ce_w[l], 0);
            chk("rst_io_ce", io_ce_w[l], 0);
            chk("rst_bus_rnw", bus_rnw_w[l], 1);
            chk("rst_bus_addr", bus_addr_w[l], 0);
            chk("rst_bus_wdata", bus_wdata_w[l], 0);
            chk("rst_dma_ack", ack_w[l], 0);
            chk("rst_clken", clken_w[l], 1);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            sel = l;
            chk("idle_clken", clken_w[l], 1);
            chk("idle_din", din_w[l], 0);
        end

        // CPU accesses: fetch W=1, IO write W=0, data write W=2, IO read W=3
        do_reset(); cpu_access(1, 1, 1, 0, 0, 1, 20'h00010, 32'h0, 32'h1234ABCD);
        do_reset(); cpu_access(0, 0, 0, 0, 1, 0, 20'h00F00, 32'hDEADBEEF, 32'h55AA0001);
        do_reset(); cpu_access(2, 2, 0, 1, 0, 0, 20'h12345, 32'hCAFEF00D, 32'h1234ABCD);
        do_reset(); cpu_access(3, 3, 0, 0, 1, 1, 20'h00F04, 32'h0, 32'h55AA0001);

        // DMA: read W=2, write W=1, read W=3 with request dropped before ack
        mem_rdata = 32'h0BADC0DE;
        do_reset(); dma_access(2, 2, 1, 20'h00400, 32'h0, 0);
        do_reset(); dma_access(1, 1, 0, 20'h00777, 32'hA5A55A5A, 0);
        do_reset(); dma_access(3, 3, 1, 20'h00404, 32'h0, 1);

        // Simultaneous single requests, W=1
        do_reset();
        sel = 1;
        cpu_vpa = 1'b1; cpu_addr = 20'h00020;
        dma_req = 1'b1; dma_rnw = 1'b1; dma_addr = 20'h00500;
        c0 = cyc;
`ifdef ARB_DMA_FAIR_EN
        sb.push_back('{1'b1, mem_rdata, c0 + 2});
        sb.push_back('{1'b0, mem_rdata, c0 + 5});
`else
        sb.push_back('{1'b0, mem_rdata, c0 + 2});
        sb.push_back('{1'b1, mem_rdata, c0 + 5});
`endif
        serve(1, 1, 1, 20);

        // Both masters requesting continuously, W=0, burst cap 2
        do_reset();
        sel = 0;
        mem_rdata = 32'h600DF00D;
        cpu_vda = 1'b1; cpu_addr = 20'h00030;
        dma_req = 1'b1; dma_addr = 20'h00600;
        c0 = cyc;
`ifdef ARB_DMA_FAIR_EN
        sb.push_back('{1'b1, mem_rdata, c0 + 1});
        sb.push_back('{1'b1, mem_rdata, c0 + 3});
        sb.push_back('{1'b0, mem_rdata, c0 + 5});
        sb.push_back('{1'b1, mem_rdata, c0 + 7});
        sb.push_back('{1'b1, mem_rdata, c0 + 9});
        sb.push_back('{1'b0, mem_rdata, c0 + 11});
        serve(0, 2, 4, 30);
`else
        sb.push_back('{1'b0, mem_rdata, c0 + 1});
        sb.push_back('{1'b0, mem_rdata, c0 + 3});
        sb.push_back('{1'b1, mem_rdata, c0 + 5});
        serve(0, 2, 1, 30);
`endif

        // Reset in the 2nd cycle of a W=3 CPU access
        do_reset();
        sel = 3;
        cpu_vpa = 1'b1; cpu_addr = 20'h00040;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_ce", mem_ce_w[3], 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_clken", clken_w[3], 1);
        chk("abort_rst_din", din_w[3], 0);
        chk("abort_rst_ack", ack_w[3], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_in();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_mem_ce", mem_ce_w[3], 0);
            chk("abort_clken", clken_w[3], 1);
            chk("abort_din", din_w[3], 0);
            chk("abort_ack", ack_w[3], 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
